uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, baud_tick pulses per bit period (even, >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port baud_tick  input  1  one-clk-wide enable pulse from the baud rate generator at OVERSAMPLE x baud rate.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port parity_en  input  1  1 = a parity bit follows the data bits.
REQ-007 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-008 SHALL have port rx_data  output  8  last received byte.
REQ-009 SHALL have port rx_valid  output  1  one-clk pulse marking a completed frame.
REQ-010 SHALL have port parity_err  output  1  parity mismatch on the frame flagged by rx_valid.
REQ-011 SHALL have port frame_err  output  1  stop bit sampled low on the frame flagged by rx_valid.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s) reset to 1; all decisions use rx_s only.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; counters tick_cnt (0..OVERSAMPLE-1) and bit_cnt (0..7).
REQ-015 SHALL advance state and counters only on clocks where baud_tick=1, except that rx_valid is deasserted on the following clock.
REQ-016 IDLE: on a tick with rx_s=0 and armed=1 -> START, tick_cnt=0, latch parity_en and parity_odd for the whole frame.
REQ-017 START: each tick increments tick_cnt; on the tick where tick_cnt==OVERSAMPLE/2-1: if rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0; if rx_s=1 -> IDLE (glitch rejected, no outputs change).
REQ-018 DATA/PARITY/STOP: each tick increments tick_cnt; on the tick where tick_cnt==OVERSAMPLE-1, sample rx_s (mid-bit) and reset tick_cnt=0.
REQ-019 DATA SHALL shift bits LSB first; after the 8th sample -> PARITY if latched parity_en=1, else STOP.
REQ-020 PARITY SHALL compare the sample with XOR(data bits) XOR latched parity_odd; a mismatch sets the pending parity error; then -> STOP.
REQ-021 STOP sample: in the same clock, rx_data <= shift register, rx_valid <= 1, frame_err <= ~sample, parity_err <= pending parity error (0 if parity disabled); state -> IDLE.
REQ-022 rx_valid SHALL be high for exactly one clk; rx_data, parity_err and frame_err SHALL hold until the next frame completes.
REQ-023 armed SHALL clear when frame_err is set and re-set on the first tick with rx_s=1; a line held low (break) therefore yields a single frame_err frame, not repeated frames.
REQ-024 Back-to-back frames: a start edge seen on a tick immediately after the STOP sample SHALL be accepted with no lost bits.
REQ-025 A tick with baud_tick held high for every clk SHALL be legal (1 bit = OVERSAMPLE clks).
REQ-026 Frame latency: rx_valid SHALL rise at OVERSAMPLE/2 + (9 or 10 with parity) x OVERSAMPLE ticks after the start-detect tick.

Reset
REQ-027 rst=1 SHALL force, at the next clk edge: state=IDLE, tick_cnt=0, bit_cnt=0, synchronizer=11, armed=1, rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, busy=0.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no rx_valid pulse; reception restarts from IDLE after release.

Verification (OVERSAMPLE=16, baud_tick=1 every clk unless noted)
REQ-029 Frame 0xA5, parity off, stop=1 -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, busy low afterward.
REQ-030 Frame 0x3C, parity_en=1, parity_odd=0, parity bit=1 (wrong) -> rx_valid, rx_data=0x3C, parity_err=1; repeat with parity bit=0 -> parity_err=0.
REQ-031 Frame 0x00 with stop bit=0, line then held low for 40 bits -> exactly one rx_valid with frame_err=1; no further rx_valid until rx returns high and a new start bit is sent.
REQ-032 rx low for 4 ticks then high -> START then IDLE, no rx_valid, rx_data unchanged.
REQ-033 rst pulsed during DATA bit 4 of 0x55, then full frame 0x81 -> no pulse for 0x55; rx_valid with rx_data=0x81.
REQ-034 baud_tick every 3rd clk, frames 0x12 then 0x34 back-to-back with 1 stop bit -> two rx_valid pulses, data 0x12 then 0x34, no errors.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
//==============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver, 8 data bits, optional even/odd
//               parity, one stop bit. Start bit is qualified at mid-bit, data,
//               parity and stop are sampled at mid-bit of each bit period.
//               A low stop bit disarms the receiver until the line returns
//               high, so a held-low line (break) yields a single frame.
// Revision    : 1.0 - initial release
//==============================================================================
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    // Last tick of the half bit used to qualify the start bit
    localparam logic [TW-1:0] c_HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    // Last tick of a full bit period (mid-bit once aligned by the start half)
    localparam logic [TW-1:0] c_BIT_LAST  = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state,    w_state_n;
    logic [TW-1:0]   r_tick_cnt, w_tick_cnt_n;
    logic [2:0]      r_bit_cnt,  w_bit_cnt_n;
    logic [7:0]      r_shift,    w_shift_n;
    logic            r_par_en,   w_par_en_n;
    logic            r_par_odd,  w_par_odd_n;
    logic            r_par_pend, w_par_pend_n;
    logic            r_armed,    w_armed_n;
    logic [7:0]      r_rx_data,  w_rx_data_n;
    logic            r_rx_valid, w_rx_valid_n;
    logic            r_par_err,  w_par_err_n;
    logic            r_frm_err,  w_frm_err_n;
    logic            r_rx_meta;
    logic            r_rx_s;

    // Two-flop synchronizer for the asynchronous serial line, idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // State, counter and output register update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_par_pend <= 1'b0;
            r_armed    <= 1'b1;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_tick_cnt <= w_tick_cnt_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_shift    <= w_shift_n;
            r_par_en   <= w_par_en_n;
            r_par_odd  <= w_par_odd_n;
            r_par_pend <= w_par_pend_n;
            r_armed    <= w_armed_n;
            r_rx_data  <= w_rx_data_n;
            r_rx_valid <= w_rx_valid_n;
            r_par_err  <= w_par_err_n;
            r_frm_err  <= w_frm_err_n;
        end
    end

    // Next-state logic: everything advances on baud ticks only, except the
    // valid strobe, which drops on the very next clock
    always_comb begin
        w_state_n    = r_state;
        w_tick_cnt_n = r_tick_cnt;
        w_bit_cnt_n  = r_bit_cnt;
        w_shift_n    = r_shift;
        w_par_en_n   = r_par_en;
        w_par_odd_n  = r_par_odd;
        w_par_pend_n = r_par_pend;
        w_armed_n    = r_armed;
        w_rx_data_n  = r_rx_data;
        w_rx_valid_n = 1'b0;
        w_par_err_n  = r_par_err;
        w_frm_err_n  = r_frm_err;

        if (baud_tick) begin
            // Any tick with the line high re-arms start detection
            if (r_rx_s) begin
                w_armed_n = 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s && r_armed) begin
                        w_state_n    = S_START;
                        w_tick_cnt_n = '0;
                        w_par_en_n   = parity_en;
                        w_par_odd_n  = parity_odd;
                        w_par_pend_n = 1'b0;
                    end
                end

                S_START: begin
                    if (r_tick_cnt == c_HALF_LAST) begin
                        w_tick_cnt_n = '0;
                        w_bit_cnt_n  = 3'd0;
                        // Line back high at mid start bit: a glitch, ignore it
                        w_state_n    = r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_tick_cnt_n = r_tick_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_tick_cnt == c_BIT_LAST) begin
                        w_tick_cnt_n = '0;
                        // LSB arrives first, so shift in from the top
                        w_shift_n    = {r_rx_s, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            w_bit_cnt_n = 3'd0;
                            w_state_n   = r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            w_bit_cnt_n = r_bit_cnt + 3'd1;
                        end
                    end else begin
                        w_tick_cnt_n = r_tick_cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (r_tick_cnt == c_BIT_LAST) begin
                        w_tick_cnt_n = '0;
                        w_par_pend_n = r_rx_s != (^r_shift ^ r_par_odd);
                        w_state_n    = S_STOP;
                    end else begin
                        w_tick_cnt_n = r_tick_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_tick_cnt == c_BIT_LAST) begin
                        w_tick_cnt_n = '0;
                        w_rx_data_n  = r_shift;
                        w_rx_valid_n = 1'b1;
                        w_frm_err_n  = ~r_rx_s;
                        w_par_err_n  = r_par_en & r_par_pend;
                        // A low stop bit disarms until the line goes high
                        if (!r_rx_s) begin
                            w_armed_n = 1'b0;
                        end
                        w_state_n    = S_IDLE;
                    end else begin
                        w_tick_cnt_n = r_tick_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_n    = S_IDLE;
                    w_tick_cnt_n = '0;
                    w_bit_cnt_n  = 3'd0;
                end
            endcase
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_par_err;
    assign frame_err  = r_frm_err;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. Frames are built bit by bit
//               from the serial-format rules; expected data, parity and
//               framing flags and latency come from plain arithmetic.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       baud_tick  = 1'b1;
    logic       rx         = 1'b1;
    logic       parity_en  = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tick_div  = 1;
    int start_cyc = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         c;
    } rec_t;

    rec_t q[$];

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .rx         (rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Free-running clock counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Record every clock on which rx_valid is seen high
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            q.push_back('{rx_data, parity_err, frame_err, cyc});
        end
    end

    // Baud tick generator: one tick every tick_div clocks
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            baud_tick = (ph == 0);
            ph = (ph >= tick_div - 1) ? 0 : ph + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (OS * tick_div) @(negedge clk);
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        repeat (bits * OS * tick_div) @(negedge clk);
    endtask

    // Serialize one frame: start, 8 data LSB first, optional parity, stop
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                              input logic pflip, input logic stopv);
        logic pbit;
        parity_en  = pen;
        parity_odd = podd;
        start_cyc  = cyc;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        if (pen) begin
            // Parity bit makes the count of ones even (or odd) over data+parity
            pbit = logic'((($countones(d) + int'(podd)) % 2) != 0) ^ pflip;
            hold_bit(pbit);
        end
        hold_bit(stopv);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                                input logic fe, output int c);
        rec_t r;
        c = -1;
        check({tag, "_pulses"}, q.size(), 1);
        if (q.size() > 0) begin
            r = q.pop_front();
            c = r.c;
            check({tag, "_data"}, r.d, d);
            check({tag, "_perr"}, r.pe, pe);
            check({tag, "_ferr"}, r.fe, fe);
        end
        q.delete();
    endtask

    initial begin
        int c;
        logic [7:0] rd;
        logic pen, podd, pflip, stopv;
        rec_t r;

        // Reset state
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data",  rx_data,    8'h00);
        check("rst_valid", rx_valid,   1'b0);
        check("rst_perr",  parity_err, 1'b0);
        check("rst_ferr",  frame_err,  1'b0);
        check("rst_busy",  busy,       1'b0);
        rst = 1'b0;
        idle(2);

        // Plain frame, also measures start-edge to rx_valid latency
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        expect_frame("a5", 8'hA5, 1'b0, 1'b0, c);
        check("a5_latency", c - start_cyc, 3 + OS / 2 + 9 * OS);
        check("a5_busy_after", busy, 1'b0);

        // Even parity, wrong parity bit then correct parity bit
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);
        expect_frame("3c_bad", 8'h3C, 1'b1, 1'b0, c);
        check("3c_latency", c - start_cyc, 3 + OS / 2 + 10 * OS);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        expect_frame("3c_good", 8'h3C, 1'b0, 1'b0, c);

        // Break: zero byte with low stop bit, line held low for 40 bits
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40 * OS) @(negedge clk);
        expect_frame("break", 8'h00, 1'b0, 1'b1, c);
        idle(3);
        check("break_no_repeat", q.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        expect_frame("after_break", 8'h5A, 1'b0, 1'b0, c);

        // Start glitch: 4 clocks low, then high
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", busy, 1'b1);
        idle(2);
        check("glitch_pulses", q.size(), 0);
        check("glitch_data", rx_data, 8'h5A);
        check("glitch_busy_after", busy, 1'b0);

        // Reset in the middle of data bit 4 of 0x55
        rd = 8'h55;
        parity_en = 1'b0;
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(rd[i]);
        rx = rd[4];
        repeat (OS / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", rx_data, 8'h00);
        rst = 1'b0;
        idle(2);
        check("midrst_pulses", q.size(), 0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        expect_frame("after_rst", 8'h81, 1'b0, 1'b0, c);

        // Slow ticks, back-to-back frames
        tick_div = 3;
        idle(2);
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("b2b_pulses", q.size(), 2);
        if (q.size() == 2) begin
            r = q.pop_front();
            check("b2b_data0", r.d, 8'h12);
            check("b2b_err0", {r.pe, r.fe}, 2'b00);
            r = q.pop_front();
            check("b2b_data1", r.d, 8'h34);
            check("b2b_err1", {r.pe, r.fe}, 2'b00);
        end
        q.delete();

        // Randomized frames against the format rules
        for (int n = 0; n < 12; n++) begin
            tick_div = 1 + int'($urandom_range(0, 2));
            idle(1);
            rd    = 8'($urandom);
            pen   = 1'($urandom);
            podd  = 1'($urandom);
            pflip = 1'($urandom);
            stopv = ($urandom_range(0, 3) != 0);
            send_frame(rd, pen, podd, pflip, stopv);
            idle(2);
            expect_frame("rand", rd, pen & pflip, ~stopv, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
